// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - runtime-programmable glitch-free clock divider with queued ratio changes.
// Optional tick counter output o_period_cnt when CLK_DIV_CTRL_PERIOD_CNT_EN is defined.
module clk_div_ctrl #(
    parameter int RATIO_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clk_en,
    input  logic               cfg_valid,
    input  logic [RATIO_W-1:0] cfg_ratio,
    output logic               cfg_ready,
    output logic               clk_divided,
    output logic               o_tick,
    output logic               o_busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    output logic [15:0]        o_period_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);

    state_t             state;
    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] active;
    logic [RATIO_W-1:0] pending;
    logic               accept;
    logic               phase_end;

    assign accept    = cfg_valid & cfg_ready;
    assign phase_end = (cnt == (active - ONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            active      <= '0;
            pending     <= '0;
            clk_divided <= 1'b0;
            o_tick      <= 1'b0;
            o_busy      <= 1'b0;
            cfg_ready   <= 1'b1;
        end else begin
            o_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && (cfg_ratio != '0)) begin
                        state       <= RUN;
                        active      <= cfg_ratio;
                        cnt         <= '0;
                        clk_divided <= 1'b1;
                        o_tick      <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                RUN, PEND: begin
                    // A request taken this cycle only queues; the boundary below still uses the old ratio.
                    if ((state == RUN) && accept) begin
                        pending   <= cfg_ratio;
                        state     <= PEND;
                        cfg_ready <= 1'b0;
                    end
                    if (i_clk_en) begin
                        if ((state == PEND) && !clk_divided && phase_end) begin
                            cnt       <= '0;
                            active    <= pending;
                            cfg_ready <= 1'b1;
                            if (pending != '0) begin
                                state       <= RUN;
                                clk_divided <= 1'b1;
                                o_tick      <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end
                        end else if (phase_end) begin
                            cnt         <= '0;
                            clk_divided <= ~clk_divided;
                            o_tick      <= ~clk_divided;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_busy    <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    // Counts each tick on the cycle after it is presented; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_period_cnt <= '0;
        end else if (o_tick) begin
            o_period_cnt <= o_period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter RATIO_W, default 8, width of the divide ratio.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_clk_en  input  1  count enable; low freezes divider progress.
REQ-005 SHALL have port cfg_valid  input  1  new-ratio request valid.
REQ-006 SHALL have port cfg_ratio  input  RATIO_W  requested half-period N in clk cycles; 0 = stop.
REQ-007 SHALL have port cfg_ready  output  1  controller can accept a request.
REQ-008 SHALL have port clk_divided  output  1  divided clock, registered, glitch-free.
REQ-009 SHALL have port o_tick  output  1  one-cycle pulse coincident with each clk_divided 0->1 edge.
REQ-010 SHALL have port o_busy  output  1  high in RUN or PEND.

Function
REQ-011 SHALL implement states IDLE (stopped), RUN (dividing), PEND (ratio change queued).
REQ-012 Request accepted SHALL be cfg_valid & cfg_ready; cfg_ready SHALL be 1 in IDLE and RUN, 0 in PEND.
REQ-013 IDLE, accepted N>0: next edge -> RUN, active=N, cnt=0, clk_divided=1, o_tick=1; accepted N=0 SHALL be a no-op.
REQ-014 RUN with i_clk_en=1: cnt==active-1 -> cnt=0 and clk_divided toggles; otherwise cnt+1; high phase = low phase = N cycles, period 2N (N=1 -> period 2).
REQ-015 o_tick SHALL be 1 only on the cycle clk_divided becomes 1; 0 otherwise.
REQ-016 RUN, accepted request: ratio stored in pending register, state -> PEND; divider continues at the active ratio.
REQ-017 PEND SHALL switch only at end of a low phase (clk_divided==0, cnt==active-1, i_clk_en=1): pending>0 -> RUN, active=pending, cnt=0, clk_divided=1, o_tick=1; pending=0 -> IDLE, clk_divided stays 0, cnt=0.
REQ-018 Request accepted on the same cycle as a low-phase end SHALL NOT apply at that boundary; it applies at the following period end.
REQ-019 i_clk_en=0 SHALL hold cnt, clk_divided, state transitions of REQ-014/017; o_tick=0; handshake still accepted per REQ-012.
REQ-020 clk_divided SHALL never have a pulse shorter than min(old N, new N) cycles.
REQ-021 cnt SHALL be RATIO_W bits, never exceeding active-1.

Reset
REQ-022 reset=1 SHALL immediately force IDLE, cnt=0, active=0, pending=0, clk_divided=0, o_tick=0, o_busy=0, cfg_ready=1.
REQ-023 Reset mid-RUN/PEND SHALL discard any pending request; first edge after release SHALL behave as IDLE.

Configuration
REQ-024 Macro CLK_DIV_CTRL_PERIOD_CNT_EN defined: extra output o_period_cnt (16 bits) SHALL count o_tick pulses, wrap 0xFFFF->0, clear on reset.
REQ-025 Macro undefined: port o_period_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 Reset release, i_clk_en=1, request N=3 -> clk_divided high 3 / low 3, o_tick every 6 cycles, o_busy=1.
REQ-027 RUN N=3, request N=1 during high phase -> cfg_ready low until switch; old low phase completes, then period 2 toggling, o_tick at switch.
REQ-028 RUN N=2, request N=0 -> clk_divided stops low at end of current low phase, state IDLE, o_busy=0, cfg_ready=1.
REQ-029 RUN N=4, i_clk_en low 5 cycles mid high phase -> clk_divided held, high phase totals 4 enabled cycles, no o_tick.
REQ-030 Reset asserted in PEND -> outputs zero same cycle; after release, no switch occurs without new request.
REQ-031 With CLK_DIV_CTRL_PERIOD_CNT_EN, N=1 for 10 periods -> o_period_cnt=10; preloaded run of 65536 ticks -> wraps to 0.
